// File: rtl/prng_stream_checker_if.sv
// Byte stream and status bundle between an LFSR byte source and its stream checker.
interface prng_stream_checker_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       din;
  logic             din_valid;
  logic             clr;
  logic             locked;
  logic             byte_err;
  logic [CNT_W-1:0] err_bits;
  logic [CNT_W-1:0] bytes_checked;
  logic             zero_flag;

  modport master (
    output din, din_valid, clr,
    input  locked, byte_err, err_bits, bytes_checked, zero_flag
  );

  modport slave (
    input  din, din_valid, clr,
    output locked, byte_err, err_bits, bytes_checked, zero_flag
  );
endinterface

// File: rtl/prng_stream_checker.sv
// Self-synchronising checker for the x^32 LFSR byte stream: lock, per-byte error pulse, statistics.
// Latency: one cycle, all outputs registered; no backpressure (every din_valid strobe is consumed).
module prng_stream_checker #(
  parameter int CNT_W      = 16,
  parameter int LOSS_LIMIT = 4
) (
  input logic                  clk,
  input logic                  res,
  prng_stream_checker_if.slave bus
);

  typedef enum logic {ACQ, LOCKED} state_t;

  state_t           state, state_nx;
  logic [31:0]      hist, hist_nx, hist_upd;
  logic [1:0]       fill, fill_nx;
  logic [7:0]       run, run_nx;
  logic [7:0]       mism;
  logic [3:0]       nerr;
  logic             byte_err_q, byte_err_nx;
  logic             zero_q, zero_nx;
  logic [CNT_W-1:0] err_q, err_nx;
  logic [CNT_W-1:0] chk_q, chk_nx;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Bits are predicted serially within the byte; the history always takes the received bit.
  always_comb begin
    hist_upd = hist;
    mism     = '0;
    for (int j = 0; j < 8; j++) begin
      mism[j]  = hist_upd[0] ^ hist_upd[10] ^ hist_upd[30] ^ hist_upd[31] ^ bus.din[j];
      hist_upd = {hist_upd[30:0], bus.din[j]};
    end
    nerr = 4'($countones(mism));
  end

  always_comb begin
    state_nx    = state;
    hist_nx     = hist;
    fill_nx     = fill;
    run_nx      = run;
    byte_err_nx = 1'b0;
    zero_nx     = zero_q;
    err_nx      = err_q;
    chk_nx      = chk_q;
    if (bus.din_valid) begin
      hist_nx = hist_upd;
      case (state)
        ACQ: begin
          if (fill == 2'd3) begin
            state_nx = LOCKED;
            fill_nx  = 2'd0;
          end else begin
            fill_nx = fill + 2'd1;
          end
        end
        LOCKED: begin
          byte_err_nx = |mism;
          chk_nx      = sat_add(chk_q, 4'd1);
          err_nx      = sat_add(err_q, nerr);
          if (hist_upd == 32'd0) zero_nx = 1'b1;
          if (|mism) begin
            if (run + 8'd1 == 8'(LOSS_LIMIT)) begin
              state_nx = ACQ;
              fill_nx  = 2'd0;
              run_nx   = 8'd0;
            end else begin
              run_nx = run + 8'd1;
            end
          end else begin
            run_nx = 8'd0;
          end
        end
        default: state_nx = ACQ;
      endcase
    end
    if (bus.clr) begin
      err_nx  = '0;
      chk_nx  = '0;
      zero_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= ACQ;
      hist       <= '0;
      fill       <= '0;
      run        <= '0;
      byte_err_q <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= '0;
      chk_q      <= '0;
    end else begin
      state      <= state_nx;
      hist       <= hist_nx;
      fill       <= fill_nx;
      run        <= run_nx;
      byte_err_q <= byte_err_nx;
      zero_q     <= zero_nx;
      err_q      <= err_nx;
      chk_q      <= chk_nx;
    end
  end

  assign bus.locked        = (state == LOCKED);
  assign bus.byte_err      = byte_err_q;
  assign bus.err_bits      = err_q;
  assign bus.bytes_checked = chk_q;
  assign bus.zero_flag     = zero_q;

endmodule
